if_fetch_unit: RTL and testbench

//   Instruction-fetch stage: the producer side of the IF/ID pipeline register. Owns the PC,

---
 rtl/if_fetch_unit_pkg.sv | 13 +
 rtl/if_fetch_buf.sv | 34 +++
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, reset PC and FSM state encoding for the instruction-fetch stage.
package if_fetch_unit_pkg;
  localparam int              DEF_XLEN     = 64;
  localparam int              DEF_INST_LEN = 32;
  localparam logic [63:0]     DEF_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/if_fetch_buf.sv
// One-entry pc/instr holding buffer; keeps a response alive while the IF/ID register stalls.
module if_fetch_buf #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clear,
  input  logic [XLEN-1:0]     pc_d,
  input  logic [INST_LEN-1:0] instr_d,
  output logic                valid,
  output logic [XLEN-1:0]     pc_q,
  output logic [INST_LEN-1:0] instr_q
);

  // clear wins over load so a flush can never resurrect stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (clear) begin
      valid   <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to imem and feeds IF/ID.
// Handshake: a request completes on imem_req_o & imem_gnt_i; fetch_valid_o & stall_n is a transfer.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter int              INST_LEN = DEF_INST_LEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_n,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                in_trap,
  input  logic [XLEN-1:0]     mtvec,
  input  logic                out_trap,
  input  logic [XLEN-1:0]     mepc,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [INST_LEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0]     pc_if_o,
  output logic [INST_LEN-1:0] instr_if_o,
  output logic                fetch_valid_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e          state;
  logic [XLEN-1:0]       pc_reg;
  logic                  kill;
  logic                  ctrl;
  logic [XLEN-1:0]       target_raw;
  logic [XLEN-1:0]       target;
  logic                  bypass;
  logic                  raw_valid;
  logic                  buf_load;
  logic                  buf_clear;
  logic                  buf_valid;
  logic [XLEN-1:0]       buf_pc;
  logic [INST_LEN-1:0]   buf_instr;

  assign ctrl = in_trap | out_trap | redirect;

  always_comb begin
    target_raw = redirect_pc;
    if (in_trap)       target_raw = mtvec;
    else if (out_trap) target_raw = mepc;
    target = {target_raw[XLEN-1:2], 2'b00};
  end

  assign bypass        = (state == S_WAIT) & imem_rvalid_i & ~kill;
  assign raw_valid     = bypass | ((state == S_HOLD) & buf_valid);
  assign fetch_valid_o = raw_valid & ~ctrl & ~kill;

  assign imem_req_o  = (state == S_REQ);
  assign imem_addr_o = imem_req_o ? pc_reg : '0;

  always_comb begin
    pc_if_o    = '0;
    instr_if_o = '0;
    if (bypass) begin
      pc_if_o    = pc_reg;
      instr_if_o = imem_rdata_i;
    end else if (state == S_HOLD) begin
      pc_if_o    = buf_pc;
      instr_if_o = buf_instr;
    end
  end

  assign buf_load  = bypass & ~ctrl & ~stall_n;
  assign buf_clear = (state == S_HOLD) & (ctrl | stall_n);

  if_fetch_buf #(
    .XLEN     (XLEN),
    .INST_LEN (INST_LEN)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load),
    .clear   (buf_clear),
    .pc_d    (pc_reg),
    .instr_d (imem_rdata_i),
    .valid   (buf_valid),
    .pc_q    (buf_pc),
    .instr_q (buf_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc_reg <= RESET_PC;
      kill   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (ctrl) pc_reg <= target;
          // a grant racing a redirect still owes us a response, which must be dropped
          if (imem_gnt_i) begin
            state <= S_WAIT;
            kill  <= ctrl;
          end
        end
        S_WAIT: begin
          if (ctrl) pc_reg <= target;
          if (imem_rvalid_i) begin
            kill <= 1'b0;
            if (kill || ctrl) begin
              state <= S_REQ;
            end else if (stall_n) begin
              state  <= S_REQ;
              pc_reg <= pc_reg + PC_STEP;
            end else begin
              state <= S_HOLD;
            end
          end else if (ctrl) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (ctrl) begin
            pc_reg <= target;
            state  <= S_REQ;
          end else if (stall_n) begin
            pc_reg <= pc_reg + PC_STEP;
            state  <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A response that was already in flight when reset hit may still land in S_IDLE.
  a_rvalid_legal: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (state == S_WAIT || state == S_IDLE));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: imem responder with random grant/latency, directed scenarios and a
// random run checked against an accepted-instruction-stream model.
module tb_if_fetch_unit;
  localparam int              XLEN     = 64;
  localparam int              INST_LEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                stall_n = 1'b1;
  logic                redirect = 1'b0;
  logic [XLEN-1:0]     redirect_pc = '0;
  logic                in_trap = 1'b0;
  logic [XLEN-1:0]     mtvec = '0;
  logic                out_trap = 1'b0;
  logic [XLEN-1:0]     mepc = '0;
  logic                imem_req_o;
  logic [XLEN-1:0]     imem_addr_o;
  logic                imem_gnt_i = 1'b0;
  logic                imem_rvalid_i = 1'b0;
  logic [INST_LEN-1:0] imem_rdata_i = '0;
  logic [XLEN-1:0]     pc_if_o;
  logic [INST_LEN-1:0] instr_if_o;
  logic                fetch_valid_o;

  int checks = 0;
  int errors = 0;
  int gnt_pct = 100;
  int lat_min = 0;
  int lat_max = 0;
  bit pend = 1'b0;
  int pend_cnt = 0;
  logic [XLEN-1:0] pend_addr = '0;
  logic [XLEN-1:0] exp_q[$];

  if_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_n       (stall_n),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .in_trap       (in_trap),
    .mtvec         (mtvec),
    .out_trap      (out_trap),
    .mepc          (mepc),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_if_o       (pc_if_o),
    .instr_if_o    (instr_if_o),
    .fetch_valid_o (fetch_valid_o)
  );

  always #5 clk = ~clk;

  // Memory image: 0x80000004 holds a nop (0x00000013), other words are address-derived.
  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return a[31:0] ^ 32'h8000_0017;
  endfunction

  // imem model: records a grant at negedge, answers after lat cycles, drives gnt randomly.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_o && imem_gnt_i) begin
        pend      = 1'b1;
        pend_addr = imem_addr_o;
        pend_cnt  = int'($urandom_range(lat_max, lat_min));
      end
      @(posedge clk);
      #1;
      if (pend && pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
        pend          = 1'b0;
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (pend) pend_cnt--;
      end
      imem_gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    stall_n  = 1'b1;
    redirect = 1'b0;
    in_trap  = 1'b0;
    out_trap = 1'b0;
    gnt_pct  = 100;
    lat_min  = 0;
    lat_max  = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (imem_req_o && imem_gnt_i) seen = 1'b1;
    end
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (fetch_valid_o) seen = 1'b1;
    end
  endtask

  task automatic wait_accept(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (fetch_valid_o && stall_n) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req_o, fetch_valid_o} !== 2'b00 || imem_addr_o !== '0 || pc_if_o !== '0 ||
        instr_if_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b valid=%b addr=%h pc=%h instr=%h, want all 0",
               imem_req_o, fetch_valid_o, imem_addr_o, pc_if_o, instr_if_o);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b0 || fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: req=%b valid=%b, want 0 0", imem_req_o, fetch_valid_o);
    end
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1 %h", imem_req_o, imem_addr_o, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    int grant_cyc;
    int cyc;
    do_reset();
    exp_q = {RESET_PC, RESET_PC + 64'd4, RESET_PC + 64'd8};
    grant_cyc = -10;
    cyc = 0;
    while (cyc < 20 && exp_q.size() > 0) begin
      @(negedge clk);
      if (imem_req_o && imem_gnt_i) begin
        checks++;
        if (imem_addr_o !== exp_q[0]) begin
          errors++;
          $display("FAIL seq_addr: addr=%h, want %h", imem_addr_o, exp_q[0]);
        end
        grant_cyc = cyc;
      end
      if (fetch_valid_o) begin
        checks++;
        if (pc_if_o !== exp_q[0] || instr_if_o !== mem_word(exp_q[0]) || cyc != grant_cyc + 1) begin
          errors++;
          $display("FAIL seq_data: pc=%h instr=%h at cycle %0d, want %h %h at cycle %0d",
                   pc_if_o, instr_if_o, cyc, exp_q[0], mem_word(exp_q[0]), grant_cyc + 1);
        end
        void'(exp_q.pop_front());
      end
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL seq_timeout: %0d fetches outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    bit seen;
    do_reset();
    wait_accept(10, seen);
    checks++;
    if (!seen || pc_if_o !== RESET_PC) begin
      errors++;
      $display("FAIL stall_first: seen=%b pc=%h, want 1 %h", seen, pc_if_o, RESET_PC);
    end
    tick();
    stall_n = 1'b0;
    wait_valid(10, seen);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (!seen || fetch_valid_o !== 1'b1 || pc_if_o !== 64'h8000_0004 ||
          instr_if_o !== 32'h0000_0013 || imem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b, want 1 80000004 00000013 0",
                 i, fetch_valid_o, pc_if_o, instr_if_o, imem_req_o);
      end
    end
    tick();
    stall_n = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_valid_o !== 1'b1 || pc_if_o !== 64'h8000_0004) begin
      errors++;
      $display("FAIL stall_release: valid=%b pc=%h, want 1 80000004", fetch_valid_o, pc_if_o);
    end
    @(negedge clk);
    checks++;
    if (fetch_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0008) begin
      errors++;
      $display("FAIL stall_next: valid=%b req=%b addr=%h, want 0 1 80000008",
               fetch_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_kill();
    bit seen;
    do_reset();
    lat_min = 2;
    lat_max = 2;
    wait_grant(10, seen);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h8000_1002;
    @(negedge clk);
    checks++;
    if (!seen || fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_redirect_cycle: granted=%b valid=%b, want 1 0", seen, fetch_valid_o);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_drop: valid=%b pc=%h on stale response, want valid 0", fetch_valid_o, pc_if_o);
    end
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_1000) begin
      errors++;
      $display("FAIL kill_next_addr: req=%b addr=%h, want 1 80001000", imem_req_o, imem_addr_o);
    end
    wait_accept(20, seen);
    checks++;
    if (!seen || pc_if_o !== 64'h8000_1000 || instr_if_o !== mem_word(64'h8000_1000)) begin
      errors++;
      $display("FAIL kill_resume: seen=%b pc=%h instr=%h, want 1 80001000 %h",
               seen, pc_if_o, instr_if_o, mem_word(64'h8000_1000));
    end
  endtask

  task automatic test_trap_priority();
    bit seen;
    do_reset();
    gnt_pct = 0;
    @(negedge clk);
    tick();
    in_trap     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_2000;
    mtvec       = 64'h8000_0100;
    mepc        = 64'h8000_0300;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL trap_req_cycle: req=%b valid=%b, want 1 0", imem_req_o, fetch_valid_o);
    end
    gnt_pct = 100;
    tick();
    in_trap  = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0100) begin
      errors++;
      $display("FAIL trap_addr: req=%b addr=%h, want 1 80000100", imem_req_o, imem_addr_o);
    end
    wait_accept(10, seen);
    checks++;
    if (!seen || pc_if_o !== 64'h8000_0100 || instr_if_o !== mem_word(64'h8000_0100)) begin
      errors++;
      $display("FAIL trap_accept: seen=%b pc=%h instr=%h, want 1 80000100 %h",
               seen, pc_if_o, instr_if_o, mem_word(64'h8000_0100));
    end
  endtask

  task automatic test_mret_hold();
    bit seen;
    do_reset();
    stall_n = 1'b0;
    wait_valid(10, seen);
    tick();
    @(negedge clk);
    checks++;
    if (!seen || fetch_valid_o !== 1'b1 || pc_if_o !== RESET_PC) begin
      errors++;
      $display("FAIL mret_held: seen=%b valid=%b pc=%h, want 1 1 %h", seen, fetch_valid_o, pc_if_o, RESET_PC);
    end
    tick();
    out_trap = 1'b1;
    mepc     = 64'h8000_0040;
    @(negedge clk);
    checks++;
    if (fetch_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mret_cycle: valid=%b req=%b, want 0 0", fetch_valid_o, imem_req_o);
    end
    tick();
    out_trap = 1'b0;
    stall_n  = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0040 || fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mret_addr: req=%b addr=%h valid=%b, want 1 80000040 0",
               imem_req_o, imem_addr_o, fetch_valid_o);
    end
    wait_accept(10, seen);
    checks++;
    if (!seen || pc_if_o !== 64'h8000_0040) begin
      errors++;
      $display("FAIL mret_accept: seen=%b pc=%h, want 1 80000040", seen, pc_if_o);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset();
    gnt_pct = 0;
    @(negedge clk);
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    gnt_pct = 100;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_align: req=%b addr=%h, want 1 fffffffffffffffc", imem_req_o, imem_addr_o);
    end
    wait_accept(10, seen);
    wait_grant(10, seen);
    checks++;
    if (!seen || imem_addr_o !== '0) begin
      errors++;
      $display("FAIL wrap_next: granted=%b addr=%h, want 1 0", seen, imem_addr_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    wait_grant(10, seen);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {imem_req_o, fetch_valid_o} !== 2'b00 || imem_addr_o !== '0 || pc_if_o !== '0 ||
        instr_if_o !== '0) begin
      errors++;
      $display("FAIL rst_async: granted=%b req=%b valid=%b addr=%h pc=%h instr=%h, want 1 and all 0",
               seen, imem_req_o, fetch_valid_o, imem_addr_o, pc_if_o, instr_if_o);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_rvalid: valid=%b req=%b, want 0 0", fetch_valid_o, imem_req_o);
    end
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC || fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_req: req=%b addr=%h valid=%b, want 1 %h 0",
               imem_req_o, imem_addr_o, fetch_valid_o, RESET_PC);
    end
    wait_accept(20, seen);
    checks++;
    if (!seen || pc_if_o !== RESET_PC || instr_if_o !== mem_word(RESET_PC)) begin
      errors++;
      $display("FAIL rst_resume: seen=%b pc=%h instr=%h, want 1 %h %h",
               seen, pc_if_o, instr_if_o, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  function automatic logic [XLEN-1:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFF0 | XLEN'($urandom_range(0, 15));
    return {$urandom, $urandom};
  endfunction

  // Model: accepted instructions form a sequential stream restarted at every redirect/trap target.
  task automatic test_random();
    logic [XLEN-1:0] model_pc;
    logic [XLEN-1:0] tgt;
    int accepts;
    do_reset();
    gnt_pct  = 70;
    lat_min  = 0;
    lat_max  = 3;
    model_pc = RESET_PC;
    accepts  = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      stall_n     = ($urandom_range(0, 3) != 0);
      in_trap     = ($urandom_range(0, 99) < 2);
      out_trap    = ($urandom_range(0, 99) < 2);
      redirect    = ($urandom_range(0, 99) < 3);
      mtvec       = rand_target();
      mepc        = rand_target();
      redirect_pc = rand_target();
      @(negedge clk);
      if (in_trap || out_trap || redirect) begin
        checks++;
        if (fetch_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_ctrl_valid: cycle %0d valid=%b, want 0", cyc, fetch_valid_o);
        end
        tgt      = in_trap ? mtvec : (out_trap ? mepc : redirect_pc);
        model_pc = tgt & ~64'h3;
      end else begin
        if (imem_req_o && imem_gnt_i) begin
          checks++;
          if (imem_addr_o !== model_pc) begin
            errors++;
            $display("FAIL rnd_addr: cycle %0d addr=%h, want %h", cyc, imem_addr_o, model_pc);
          end
        end
        if (fetch_valid_o) begin
          checks++;
          if (pc_if_o !== model_pc || instr_if_o !== mem_word(model_pc)) begin
            errors++;
            $display("FAIL rnd_data: cycle %0d pc=%h instr=%h, want %h %h",
                     cyc, pc_if_o, instr_if_o, model_pc, mem_word(model_pc));
          end
          if (stall_n) begin
            model_pc = model_pc + 64'd4;
            accepts++;
          end
        end
      end
    end
    redirect = 1'b0;
    in_trap  = 1'b0;
    out_trap = 1'b0;
    checks++;
    if (accepts < 20) begin
      errors++;
      $display("FAIL rnd_progress: %0d instructions accepted, want at least 20", accepts);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_kill();
    test_trap_priority();
    test_mret_hold();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
